// File: rtl/regfile_tagged_if.sv
// Issue/commit/read bundle between decode, ROB and the tagged register file.
// The register file takes the slave side; the issue/ROB logic drives the master side.
interface regfile_tagged_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned IDX_W  = 5,
   parameter int unsigned TAG_W  = 4
) ();

   logic              flush_in;
   logic              commitE_in;
   logic [IDX_W-1:0]  commitIdx_in;
   logic [TAG_W-1:0]  commitTag_in;
   logic [DATA_W-1:0] commitData_in;
   logic              renameE_in;
   logic [IDX_W-1:0]  renameIdx_in;
   logic [TAG_W-1:0]  renameTag_in;
   logic              reg1E_in;
   logic [IDX_W-1:0]  reg1Idx_in;
   logic              reg2E_in;
   logic [IDX_W-1:0]  reg2Idx_in;
   logic [DATA_W-1:0] reg1Data_out;
   logic              reg1Busy_out;
   logic [TAG_W-1:0]  reg1Tag_out;
   logic [DATA_W-1:0] reg2Data_out;
   logic              reg2Busy_out;
   logic [TAG_W-1:0]  reg2Tag_out;
   logic [IDX_W:0]    busyCnt_out;

   modport master (
      output flush_in, commitE_in, commitIdx_in, commitTag_in, commitData_in,
      output renameE_in, renameIdx_in, renameTag_in,
      output reg1E_in, reg1Idx_in, reg2E_in, reg2Idx_in,
      input  reg1Data_out, reg1Busy_out, reg1Tag_out,
      input  reg2Data_out, reg2Busy_out, reg2Tag_out, busyCnt_out
   );

   modport slave (
      input  flush_in, commitE_in, commitIdx_in, commitTag_in, commitData_in,
      input  renameE_in, renameIdx_in, renameTag_in,
      input  reg1E_in, reg1Idx_in, reg2E_in, reg2Idx_in,
      output reg1Data_out, reg1Busy_out, reg1Tag_out,
      output reg2Data_out, reg2Busy_out, reg2Tag_out, busyCnt_out
   );

endinterface

// File: rtl/regfile_tagged.sv
// Architectural register file with per-register busy bit and ROB rename tag.
// Two combinational read ports with commit bypass, one rename and one commit per cycle.
module regfile_tagged #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned REG_NUM = 32,
   parameter int unsigned IDX_W   = 5,
   parameter int unsigned TAG_W   = 4
) (
   input logic             clk_in,
   input logic             rst_in,
   regfile_tagged_if.slave bus_if
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              busy;
      logic [TAG_W-1:0]  tag;
   } rd_t;

   logic [DATA_W-1:0]  data_q [REG_NUM];
   logic [DATA_W-1:0]  data_d [REG_NUM];
   logic [TAG_W-1:0]   tag_q  [REG_NUM];
   logic [TAG_W-1:0]   tag_d  [REG_NUM];
   logic [REG_NUM-1:0] busy_q, busy_d;
   logic [IDX_W:0]     cnt_q, cnt_d;

   logic rename_v, commit_v, commit_clr, cnt_inc;
   rd_t  rd1, rd2;

   assign rename_v = bus_if.renameE_in && (bus_if.renameIdx_in != '0);
   assign commit_v = bus_if.commitE_in && (bus_if.commitIdx_in != '0);

   // A commit only retires the mapping it produced; a same-index rename keeps the reg busy.
   assign commit_clr = commit_v && busy_q[bus_if.commitIdx_in]
                       && (tag_q[bus_if.commitIdx_in] == bus_if.commitTag_in)
                       && !(rename_v && (bus_if.renameIdx_in == bus_if.commitIdx_in));
   assign cnt_inc    = rename_v && !busy_q[bus_if.renameIdx_in];

   always_comb begin
      data_d = data_q;
      tag_d  = tag_q;
      busy_d = busy_q;
      cnt_d  = cnt_q;
      if (commit_v) begin
         data_d[bus_if.commitIdx_in] = bus_if.commitData_in;
      end
      if (bus_if.flush_in) begin
         busy_d = '0;
         cnt_d  = '0;
      end else begin
         if (commit_clr) begin
            busy_d[bus_if.commitIdx_in] = 1'b0;
         end
         if (rename_v) begin
            busy_d[bus_if.renameIdx_in] = 1'b1;
            tag_d[bus_if.renameIdx_in]  = bus_if.renameTag_in;
         end
         cnt_d = cnt_q + {{IDX_W{1'b0}}, cnt_inc} - {{IDX_W{1'b0}}, commit_clr};
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < int'(REG_NUM); i++) begin
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         tag_q  <= tag_d;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   function automatic rd_t rd_port(input logic en, input logic [IDX_W-1:0] idx);
      rd_t r;
      r = '0;
      if (!rst_in && en && (idx != '0)) begin
         r.data = data_q[idx];
         r.busy = busy_q[idx];
         r.tag  = tag_q[idx];
         if (bus_if.commitE_in && (bus_if.commitIdx_in == idx)) begin
            r.data = bus_if.commitData_in;
            if (tag_q[idx] == bus_if.commitTag_in) begin
               r.busy = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      rd1 = rd_port(bus_if.reg1E_in, bus_if.reg1Idx_in);
      rd2 = rd_port(bus_if.reg2E_in, bus_if.reg2Idx_in);
   end

   assign bus_if.reg1Data_out = rd1.data;
   assign bus_if.reg1Busy_out = rd1.busy;
   assign bus_if.reg1Tag_out  = rd1.tag;
   assign bus_if.reg2Data_out = rd2.data;
   assign bus_if.reg2Busy_out = rd2.busy;
   assign bus_if.reg2Tag_out  = rd2.tag;
   assign bus_if.busyCnt_out  = cnt_q;

endmodule

// File: doc/regfile_tagged.md
# regfile_tagged

Parametrised architectural register file with per-register busy bits and rename tags for the out-of-order core. It sits between decode/issue and the reorder buffer. Issue reads two sources and renames one destination per cycle; commit retires one result per cycle; a flush drops all pending renames after a mispredict. Register 0 is hardwired to zero and is never renamed.

## Interface
- DATA_W, 32, register data width
- REG_NUM, 32, number of architectural registers (power of two, ≥2)
- IDX_W, 5, register index width, equal to log2(REG_NUM)
- TAG_W, 4, ROB tag width
- clk_in  input  1  clock; all state updates on the rising edge
- rst_in  input  1  synchronous, active-high reset
- flush_in  input  1  discard all renames (mispredict recovery)
- commitE_in  input  1  commit write enable
- commitIdx_in  input  IDX_W  commit destination register
- commitTag_in  input  TAG_W  ROB tag of the committing instruction
- commitData_in  input  DATA_W  commit result
- renameE_in  input  1  issue rename enable
- renameIdx_in  input  IDX_W  destination being renamed
- renameTag_in  input  TAG_W  ROB tag assigned to the destination
- reg1E_in / reg2E_in  input  1  source read enables
- reg1Idx_in / reg2Idx_in  input  IDX_W  source indices
- reg1Data_out / reg2Data_out  output  DATA_W  source value
- reg1Busy_out / reg2Busy_out  output  1  source still pending in the ROB
- reg1Tag_out / reg2Tag_out  output  TAG_W  producing ROB tag, valid when busy
- busyCnt_out  output  IDX_W+1  registered count of busy registers

## Operation
- State per register: data[DATA_W], busy, tag[TAG_W]. Reg 0 reads as data 0, busy 0, tag 0 at all times.
- Read port k is combinational, evaluated in priority order:
  - rst_in high -> data 0, busy 0, tag 0.
  - Idx 0 or enable low -> data 0, busy 0, tag 0.
  - Commit bypass when commitE_in && commitIdx_in == idx: data = commitData_in. Busy and tag come from the array, except busy = 0 when the stored tag == commitTag_in.
  - Otherwise -> array contents.
- Reads never see a same-cycle rename. An instruction with rs == rd reads the old mapping.
- Commit, at the clock edge, when idx != 0:
  - data[idx] is always written.
  - busy[idx] is cleared only if busy[idx] is set and tag[idx] == commitTag_in. A stale commit (a younger rename is outstanding) writes data but leaves busy set.
- Rename, at the clock edge, when idx != 0 and flush_in is low: busy[idx] <= 1 and tag[idx] <= renameTag_in.
- Priority for busy/tag:
  - rst_in > flush_in (all busy <= 0; tags keep their values) > rename > commit-clear.
  - Commit data is still written during a flush cycle.
  - Rename and commit to the same idx in one cycle: data takes commitData_in, busy = 1, tag = renameTag_in.
- busyCnt_out tracks the number of set busy bits after each edge:
  - +1 for a rename of a non-busy register.
  - −1 for a matching commit-clear that is not overridden by a same-index rename.
  - Net 0 when both events occur on different registers with the same effect.
  - 0 after flush or reset.
  - Never exceeds REG_NUM−1.

## Timing
- Reset: one cycle with rst_in high clears every data, busy and tag entry and busyCnt_out to 0. Read outputs are 0 while rst_in is high.
- Reset mid-operation overrides any same-cycle commit, rename or flush.
- Read latency: 0 cycles (combinational), including commit bypass.
- Commit and rename effects are visible through the array on the cycle after the edge.
- busyCnt_out is registered and updates at the same edge as the busy bits.
- No backpressure: commit and rename are accepted every cycle. Issue must not rename with a tag still in flight to a different register (the ROB guarantees this).

## Test plan
- Reset, then read r5 -> data 0, busy 0, busyCnt_out 0. Commit r5 = 0xDEADBEEF tag 3 with r5 not busy -> same-cycle read returns 0xDEADBEEF, busy 0; next cycle the array returns the same.
- Rename r7 tag 2; next cycle reads r7 -> busy 1, tag 2, busyCnt_out 1. Commit r7 tag 2 data 0x11 -> same-cycle read gives data 0x11, busy 0; next cycle busyCnt_out 0.
- Rename r7 tag 2, then rename r7 tag 5, then commit r7 tag 2 data 0x22 -> data 0x22, busy stays 1, tag 5, busyCnt_out 1. Commit tag 5 -> busy 0.
- Same cycle: rename r3 tag 4 and commit r3 (tag matching the prior rename) data 0x33 -> next cycle data 0x33, busy 1, tag 4, busyCnt_out unchanged.
- Rename r1, r2, r3, then flush_in together with a rename of r4 and a commit of r6 = 0x66 -> all busy 0, r4 not renamed, r6 = 0x66, busyCnt_out 0.
- Commit and rename to r0 -> reads of r0 stay 0 / busy 0, busyCnt_out unchanged. Assert rst_in while r9 is busy -> next cycle all 0.
